// File: rtl/uv_intc_apb.sv
// rtl/uv_intc_apb.sv - interrupt collector with APB register port
// Synchronises source lines, latches level/edge pending bits, masks, combines and claims by priority.
module uv_intc_apb #(
    parameter int ALEN       = 12,
    parameter int DLEN       = 32,
    parameter int MLEN       = DLEN / 8,
    parameter int SRC_NUM    = 8,
    parameter int SYNC_STAGE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                intc_psel,
    input  logic                intc_penable,
    input  logic [2:0]          intc_pprot,
    input  logic [ALEN-1:0]     intc_paddr,
    input  logic [MLEN-1:0]     intc_pstrb,
    input  logic                intc_pwrite,
    input  logic [DLEN-1:0]     intc_pwdata,
    output logic [DLEN-1:0]     intc_prdata,
    output logic                intc_pready,
    output logic                intc_pslverr,
    input  logic [SRC_NUM-1:0]  src_in,
    output logic                intc_irq
);

    localparam int IW = ALEN - 2;

    logic [SRC_NUM-1:0] sync_q [SYNC_STAGE];
    logic [SRC_NUM-1:0] src_s, src_p_q;
    logic [SRC_NUM-1:0] en_q, en_d, type_q, type_d, edge_q, edge_d;
    logic [SRC_NUM-1:0] pend, act, wmask, w1c, claim_oh, claim_clr;
    logic [4:0]         claim_val;
    logic [IW-1:0]      widx;
    logic               setup, bad, irq_q;
    logic [DLEN-1:0]    rdata, prdata_q;
    logic               pready_q, pslverr_q;
    logic               unused_bits;

    assign unused_bits = ^{intc_pprot, intc_paddr[1:0], intc_pwdata, intc_pstrb};

    assign src_s = sync_q[SYNC_STAGE-1];
    assign setup = intc_psel & ~intc_penable;
    assign widx  = intc_paddr[ALEN-1:2];
    assign bad   = widx > IW'(3);

    // Level sources read the synchronised line directly; edge sources use the latched bit.
    assign pend = (type_q & edge_q) | (~type_q & src_s);
    assign act  = pend & en_q;

    always_comb begin
        wmask     = '0;
        claim_val = '0;
        claim_oh  = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            wmask[i] = intc_pstrb[i/8];
        end
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (act[i]) begin
                claim_val   = 5'(i + 1);
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        en_d      = en_q;
        type_d    = type_q;
        w1c       = '0;
        claim_clr = '0;
        rdata     = '0;
        if (setup && intc_pwrite) begin
            if (widx == IW'(0)) en_d   = (en_q & ~wmask) | (intc_pwdata[SRC_NUM-1:0] & wmask);
            if (widx == IW'(1)) type_d = (type_q & ~wmask) | (intc_pwdata[SRC_NUM-1:0] & wmask);
            if (widx == IW'(2)) w1c    = intc_pwdata[SRC_NUM-1:0] & wmask;
        end
        if (setup && !intc_pwrite && widx == IW'(3)) claim_clr = claim_oh;
        case (widx)
            IW'(0):  rdata = DLEN'(en_q);
            IW'(1):  rdata = DLEN'(type_q);
            IW'(2):  rdata = DLEN'(pend);
            IW'(3):  rdata = DLEN'(claim_val);
            default: rdata = '0;
        endcase
        // A new rising edge in the same cycle as a clear keeps the bit set.
        edge_d = type_q & ((edge_q & ~(w1c | claim_clr)) | (src_s & ~src_p_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGE; i++) sync_q[i] <= '0;
            src_p_q   <= '0;
            en_q      <= '0;
            type_q    <= '0;
            edge_q    <= '0;
            irq_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            sync_q[0] <= src_in;
            for (int i = 1; i < SYNC_STAGE; i++) sync_q[i] <= sync_q[i-1];
            src_p_q   <= src_s;
            en_q      <= en_d;
            type_q    <= type_d;
            edge_q    <= edge_d;
            irq_q     <= |act;
            pready_q  <= setup;
            pslverr_q <= setup & bad;
            if (setup && !intc_pwrite) prdata_q <= rdata;
        end
    end

    assign intc_prdata  = prdata_q;
    assign intc_pready  = pready_q;
    assign intc_pslverr = pslverr_q;
    assign intc_irq     = irq_q;

endmodule

// File: tb/tb_uv_intc_apb.sv
// tb/tb_uv_intc_apb.sv - self-checking bench for uv_intc_apb
module tb_uv_intc_apb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  pprot = 3'b0;
    logic [11:0] paddr = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq;
    logic [7:0]  src = '0;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  idx;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    uv_intc_apb dut (
        .clk(clk), .rst_n(rst_n),
        .intc_psel(psel), .intc_penable(penable), .intc_pprot(pprot),
        .intc_paddr(paddr), .intc_pstrb(pstrb), .intc_pwrite(pwrite),
        .intc_pwdata(pwdata), .intc_prdata(prdata), .intc_pready(pready),
        .intc_pslverr(pslverr), .src_in(src), .intc_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge one cycle after the access phase.
    task automatic apb(input logic wr, input logic [9:0] idx, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {idx, 2'b00};
        pstrb = strb; pwdata = wdata;
        @(negedge clk);
        check("pready_high", 32'(pready), 32'd1);
        rd  = prdata;
        err = pslverr;
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("pready_low", 32'(pready), 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [9:0] idx, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, idx, 4'hF, 32'h0, rd, err);
        check(name, rd, exp);
    endtask

    task automatic wr(input logic [9:0] idx, input logic [31:0] data);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, idx, 4'hF, data, rd, err);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd;
        logic        err;

        tbl.push_back('{1'b0, 10'd0, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd1, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd2, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd3, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b1, 10'd0, 4'hF, 32'h000000A5, 32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd0, 4'hF, 32'h0,        32'hA5, 1'b0});
        tbl.push_back('{1'b1, 10'd1, 4'hF, 32'h0000003C, 32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd1, 4'hF, 32'h0,        32'h3C, 1'b0});
        tbl.push_back('{1'b1, 10'd0, 4'h0, 32'hFFFFFF00, 32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd0, 4'hF, 32'h0,        32'hA5, 1'b0});
        tbl.push_back('{1'b1, 10'd0, 4'h2, 32'h0000FF00, 32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd0, 4'hF, 32'h0,        32'hA5, 1'b0});
        tbl.push_back('{1'b1, 10'd0, 4'hF, 32'hFFFFFFFF, 32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd0, 4'hF, 32'h0,        32'hFF, 1'b0});
        tbl.push_back('{1'b0, 10'd4, 4'hF, 32'h0,        32'h0,  1'b1});
        tbl.push_back('{1'b1, 10'd3, 4'hF, 32'hFFFFFFFF, 32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd3, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b1, 10'd5, 4'hF, 32'h0,        32'h0,  1'b1});
        tbl.push_back('{1'b1, 10'd1, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b1, 10'd0, 4'hF, 32'h0,        32'h0,  1'b0});
        tbl.push_back('{1'b0, 10'd2, 4'hF, 32'h0,        32'h0,  1'b0});

        wait_clk(3);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        rst_n = 1'b1;
        wait_clk(2);

        foreach (tbl[i]) begin
            apb(tbl[i].wr, tbl[i].idx, tbl[i].strb, tbl[i].wdata, rd, err);
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
            if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
        end

        // level mode pending follows all lines
        src = 8'hFF;
        wait_clk(3);
        rd_chk("level_pend_all", 10'd2, 32'hFF);
        check("level_all_irq_masked", 32'(irq), 32'd0);
        src = 8'h00;
        wait_clk(3);

        // level latency
        wr(10'd0, 32'h1);
        src[0] = 1'b1;
        wait_clk(2);
        check("lvl_irq_early", 32'(irq), 32'd0);
        wait_clk(1);
        check("lvl_irq_on", 32'(irq), 32'd1);
        src[0] = 1'b0;
        wait_clk(2);
        check("lvl_irq_hold", 32'(irq), 32'd1);
        wait_clk(1);
        check("lvl_irq_off", 32'(irq), 32'd0);

        // edge + W1C
        wr(10'd1, 32'h04);
        wr(10'd0, 32'h04);
        src[2] = 1'b1;
        wait_clk(5);
        src[2] = 1'b0;
        wait_clk(3);
        rd_chk("edge_pend", 10'd2, 32'h04);
        check("edge_irq_on", 32'(irq), 32'd1);
        wr(10'd2, 32'h04);
        check("w1c_irq_off", 32'(irq), 32'd0);
        rd_chk("w1c_pend", 10'd2, 32'h0);

        // claim priority
        wr(10'd1, 32'h4A);
        wr(10'd0, 32'hFF);
        src = 8'h4A;
        wait_clk(4);
        src = 8'h00;
        wait_clk(3);
        rd_chk("claim_1", 10'd3, 32'd2);
        rd_chk("claim_2", 10'd3, 32'd4);
        check("claim_irq_mid", 32'(irq), 32'd1);
        rd_chk("claim_3", 10'd3, 32'd7);
        check("claim_irq_off", 32'(irq), 32'd0);
        rd_chk("claim_4", 10'd3, 32'd0);

        // collision: new edge lands in the same cycle as W1C
        wr(10'd1, 32'h20);
        wr(10'd0, 32'h20);
        src[5] = 1'b1;
        wait_clk(4);
        src[5] = 1'b0;
        wait_clk(4);
        rd_chk("coll_pre", 10'd2, 32'h20);
        src[5] = 1'b1;
        wait_clk(2);
        wr(10'd2, 32'h20);
        rd_chk("coll_pend", 10'd2, 32'h20);
        check("coll_irq", 32'(irq), 32'd1);
        wr(10'd2, 32'h20);
        rd_chk("coll_clear", 10'd2, 32'h0);
        check("coll_irq_off", 32'(irq), 32'd0);

        // asynchronous reset mid-operation
        wr(10'd1, 32'h0);
        wr(10'd0, 32'hFF);
        wait_clk(2);
        check("pre_rst_irq", 32'(irq), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_irq", 32'(irq), 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(1);
        rd_chk("post_rst_en", 10'd0, 32'h0);
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
